// File: rtl/fill_pkg.sv
// Shared encodings, fault codes and timing defaults for the pill-bottle fill sequencer.
package fill_pkg;

   typedef enum logic [2:0] {
      ST_SETTING   = 3'd0,
      ST_RUNNING   = 3'd1,
      ST_SWITCHING = 3'd2,
      ST_DONE      = 3'd3,
      ST_ERROR     = 3'd4,
      ST_FATAL     = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_HOPPER   = 2'd1,
      ERR_CONVEYOR = 2'd2,
      ERR_ESTOP    = 2'd3
   } err_t;

   localparam int DEF_CLK_HZ   = 1000;
   localparam int DEF_SWITCH_S = 2;
   localparam int DEF_HOPPER_S = 3;
   localparam int TIMER_W      = 8;

   function automatic logic [3:0] bcd_digit_inc(input logic [3:0] d);
      return (d == 4'd9) ? 4'd0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD counter with synchronous clear/increment and a target-hit flag.
// CMP_NEXT selects whether the hit compares the held value or the value after one increment.
module bcd_counter
   import fill_pkg::*;
#(
   parameter int DIGITS   = 3,
   parameter bit CMP_NEXT = 1'b0
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_clr,
   input  logic                  i_inc,
   input  logic [4*DIGITS-1:0]   i_cmp,
   output logic [4*DIGITS-1:0]   o_value,
   output logic                  o_hit
);

   logic [4*DIGITS-1:0] r_value;
   logic [4*DIGITS-1:0] w_inc;
   logic [DIGITS-1:0]   w_carry;

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         if (gi == 0) begin : g_lsd
            assign w_carry[gi] = 1'b1;
         end else begin : g_upper
            // A digit advances only when every lower digit is rolling over from 9.
            assign w_carry[gi] = w_carry[gi-1] & (r_value[4*(gi-1) +: 4] == 4'd9);
         end
         assign w_inc[4*gi +: 4] = w_carry[gi] ? bcd_digit_inc(r_value[4*gi +: 4])
                                               : r_value[4*gi +: 4];
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_value <= '0;
      end else if (i_clr) begin
         r_value <= '0;
      end else if (i_inc) begin
         r_value <= w_inc;
      end
   end

   generate
      if (CMP_NEXT) begin : g_hit_next
         assign o_hit = (w_inc == i_cmp);
      end else begin : g_hit_now
         assign o_hit = (r_value == i_cmp);
      end
   endgenerate

   assign o_value = r_value;

endmodule

// File: rtl/fill_sequencer.sv
// Pill-bottle fill sequencer: counts pills into bottles, dwells while the conveyor swaps
// bottles, and latches hopper, conveyor and emergency-stop faults.
module fill_sequencer
   import fill_pkg::*;
#(
   parameter int CLK_HZ   = DEF_CLK_HZ,
   parameter int SWITCH_S = DEF_SWITCH_S,
   parameter int HOPPER_S = DEF_HOPPER_S
) (
   input  logic        clk_1khz,
   input  logic        clr_n,
   input  logic        start,
   input  logic        pill_pulse,
   input  logic        conveyor_ok,
   input  logic        estop,
   input  logic [11:0] tgt_pills,
   input  logic [7:0]  tgt_bottles,
   output logic [2:0]  state,
   output logic [11:0] now_pills,
   output logic [7:0]  now_bottles,
   output logic        hopper_en,
   output logic        conveyor_run,
   output logic [1:0]  err_code,
   output logic        done
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0]      PRESC_MAX = PW'(CLK_HZ - 1);
   localparam logic [TIMER_W-1:0] HOP_LOAD  = TIMER_W'(HOPPER_S);
   localparam logic [TIMER_W-1:0] SW_LOAD   = TIMER_W'(SWITCH_S);

   state_t              r_state, w_state_next;
   err_t                r_err, w_err_next;
   logic [TIMER_W-1:0]  r_hop, w_hop_next;
   logic [TIMER_W-1:0]  r_sw, w_sw_next;
   logic [PW-1:0]       r_presc;
   logic                r_hopper_en, r_conveyor_run, r_done;

   logic w_tick, w_load;
   logic w_cnt_clr, w_pill_clr, w_pill_inc, w_btl_inc;
   logic w_pill_hit, w_btl_hit;

   bcd_counter #(
      .DIGITS   (3),
      .CMP_NEXT (1'b0)
   ) u_pills (
      .i_clk   (clk_1khz),
      .i_rst_n (clr_n),
      .i_clr   (w_cnt_clr | w_pill_clr),
      .i_inc   (w_pill_inc),
      .i_cmp   (tgt_pills),
      .o_value (now_pills),
      .o_hit   (w_pill_hit)
   );

   // The bottle hit looks ahead one increment so DONE is chosen on the completing edge.
   bcd_counter #(
      .DIGITS   (2),
      .CMP_NEXT (1'b1)
   ) u_bottles (
      .i_clk   (clk_1khz),
      .i_rst_n (clr_n),
      .i_clr   (w_cnt_clr),
      .i_inc   (w_btl_inc),
      .i_cmp   (tgt_bottles),
      .o_value (now_bottles),
      .o_hit   (w_btl_hit)
   );

   assign w_tick = (r_presc == PRESC_MAX);

   always_ff @(posedge clk_1khz) begin
      if (!clr_n) begin
         r_presc <= '0;
      end else if (w_load || w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_err_next   = r_err;
      w_hop_next   = r_hop;
      w_sw_next    = r_sw;
      w_load       = 1'b0;
      w_cnt_clr    = 1'b0;
      w_pill_clr   = 1'b0;
      w_pill_inc   = 1'b0;
      w_btl_inc    = 1'b0;
      if (estop && (r_state != ST_SETTING)) begin
         w_state_next = ST_FATAL;
         w_err_next   = ERR_ESTOP;
      end else begin
         case (r_state)
            ST_SETTING: begin
               if (start && (tgt_pills != '0) && (tgt_bottles != '0)) begin
                  w_cnt_clr    = 1'b1;
                  w_hop_next   = HOP_LOAD;
                  w_load       = 1'b1;
                  w_state_next = ST_RUNNING;
               end
            end
            ST_RUNNING: begin
               // Completion wins over a same-cycle pill (discarded) and over timeout.
               if (w_pill_hit) begin
                  w_pill_clr = 1'b1;
                  w_btl_inc  = 1'b1;
                  if (w_btl_hit) begin
                     w_state_next = ST_DONE;
                  end else begin
                     w_sw_next    = SW_LOAD;
                     w_load       = 1'b1;
                     w_state_next = ST_SWITCHING;
                  end
               end else if (pill_pulse) begin
                  w_pill_inc = 1'b1;
                  w_hop_next = HOP_LOAD;
                  w_load     = 1'b1;
               end else if (r_hop == '0) begin
                  w_state_next = ST_ERROR;
                  w_err_next   = ERR_HOPPER;
               end else if (w_tick) begin
                  w_hop_next = r_hop - TIMER_W'(1);
               end
            end
            ST_SWITCHING: begin
               if (r_sw == '0) begin
                  if (conveyor_ok) begin
                     w_hop_next   = HOP_LOAD;
                     w_load       = 1'b1;
                     w_state_next = ST_RUNNING;
                  end else begin
                     w_state_next = ST_ERROR;
                     w_err_next   = ERR_CONVEYOR;
                  end
               end else if (w_tick) begin
                  w_sw_next = r_sw - TIMER_W'(1);
               end
            end
            ST_DONE: begin
               if (start) begin
                  w_state_next = ST_SETTING;
               end
            end
            ST_ERROR: begin
               if (start) begin
                  w_err_next = ERR_NONE;
                  w_load     = 1'b1;
                  if (r_err == ERR_HOPPER) begin
                     w_hop_next   = HOP_LOAD;
                     w_state_next = ST_RUNNING;
                  end else begin
                     w_sw_next    = SW_LOAD;
                     w_state_next = ST_SWITCHING;
                  end
               end
            end
            ST_FATAL: begin
               w_state_next = ST_FATAL;
            end
            default: begin
               w_state_next = ST_SETTING;
            end
         endcase
      end
   end

   always_ff @(posedge clk_1khz) begin
      if (!clr_n) begin
         r_state        <= ST_SETTING;
         r_err          <= ERR_NONE;
         r_hop          <= '0;
         r_sw           <= '0;
         r_hopper_en    <= 1'b0;
         r_conveyor_run <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_err          <= w_err_next;
         r_hop          <= w_hop_next;
         r_sw           <= w_sw_next;
         r_hopper_en    <= (w_state_next == ST_RUNNING);
         r_conveyor_run <= (w_state_next == ST_SWITCHING);
         r_done         <= (w_state_next == ST_DONE) && (r_state != ST_DONE);
      end
   end

   assign state        = r_state;
   assign err_code     = r_err;
   assign hopper_en    = r_hopper_en;
   assign conveyor_run = r_conveyor_run;
   assign done         = r_done;

endmodule

// File: tb/tb_fill_sequencer.sv
// Directed bench for fill_sequencer with a cycle-countdown reference model checked every cycle.
module tb_fill_sequencer;

   localparam int HOP_CYC = 3 * 1000;
   localparam int SW_CYC  = 2 * 1000;

   logic        clk_1khz = 1'b0;
   logic        clr_n = 1'b0;
   logic        start = 1'b0;
   logic        pill_pulse = 1'b0;
   logic        conveyor_ok = 1'b1;
   logic        estop = 1'b0;
   logic [11:0] tgt_pills = 12'h000;
   logic [7:0]  tgt_bottles = 8'h00;
   logic [2:0]  state;
   logic [11:0] now_pills;
   logic [7:0]  now_bottles;
   logic        hopper_en;
   logic        conveyor_run;
   logic [1:0]  err_code;
   logic        done;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;
   int done_cnt = 0;

   // Model state: decimal counts and timers as remaining clock cycles.
   int m_st = 0, m_pills = 0, m_btl = 0, m_err = 0, m_h = 0, m_s = 0;
   bit m_done = 1'b0;

   fill_sequencer dut (
      .clk_1khz     (clk_1khz),
      .clr_n        (clr_n),
      .start        (start),
      .pill_pulse   (pill_pulse),
      .conveyor_ok  (conveyor_ok),
      .estop        (estop),
      .tgt_pills    (tgt_pills),
      .tgt_bottles  (tgt_bottles),
      .state        (state),
      .now_pills    (now_pills),
      .now_bottles  (now_bottles),
      .hopper_en    (hopper_en),
      .conveyor_run (conveyor_run),
      .err_code     (err_code),
      .done         (done)
   );

   always #5 clk_1khz = ~clk_1khz;

   function automatic int bcd2int(input logic [11:0] v);
      return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [11:0] int2bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int tp, tb;
      tp = bcd2int(tgt_pills);
      tb = bcd2int({4'h0, tgt_bottles});
      m_done = 1'b0;
      if (!clr_n) begin
         m_st = 0; m_pills = 0; m_btl = 0; m_err = 0; m_h = 0; m_s = 0;
      end else if (estop && m_st != 0) begin
         m_st = 5; m_err = 3;
      end else begin
         case (m_st)
            0: if (start && tp != 0 && tb != 0) begin
                  m_pills = 0; m_btl = 0; m_h = HOP_CYC; m_st = 1;
               end
            1: if (m_pills == tp) begin
                  m_pills = 0;
                  m_btl = (m_btl + 1) % 100;
                  if (m_btl == tb) begin
                     m_st = 3; m_done = 1'b1;
                  end else begin
                     m_s = SW_CYC; m_st = 2;
                  end
               end else if (pill_pulse) begin
                  m_pills = (m_pills + 1) % 1000; m_h = HOP_CYC;
               end else if (m_h == 0) begin
                  m_st = 4; m_err = 1;
               end else begin
                  m_h--;
               end
            2: if (m_s == 0) begin
                  if (conveyor_ok) begin
                     m_h = HOP_CYC; m_st = 1;
                  end else begin
                     m_st = 4; m_err = 2;
                  end
               end else begin
                  m_s--;
               end
            3: if (start) m_st = 0;
            4: if (start) begin
                  if (m_err == 1) begin
                     m_h = HOP_CYC; m_st = 1;
                  end else begin
                     m_s = SW_CYC; m_st = 2;
                  end
                  m_err = 0;
               end
            default: ;
         endcase
      end
   endtask

   initial forever begin
      @(posedge clk_1khz);
      model_step();
   end

   initial forever begin
      @(negedge clk_1khz);
      if (chk_en) begin
         chk("cyc_state", {29'd0, state}, m_st);
         chk("cyc_pills", {20'd0, now_pills}, {20'd0, int2bcd(m_pills)});
         chk("cyc_bottles", {24'd0, now_bottles}, {24'd0, int2bcd(m_btl)});
         chk("cyc_hopper_en", {31'd0, hopper_en}, (m_st == 1) ? 1 : 0);
         chk("cyc_conveyor_run", {31'd0, conveyor_run}, (m_st == 2) ? 1 : 0);
         chk("cyc_err", {30'd0, err_code}, m_err);
         chk("cyc_done", {31'd0, done}, {31'd0, m_done});
         if (done === 1'b1) done_cnt++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk_1khz);
   endtask

   task automatic pulse_start();
      @(negedge clk_1khz); start = 1'b1;
      @(negedge clk_1khz); start = 1'b0;
   endtask

   task automatic pulse_pill();
      @(negedge clk_1khz); pill_pulse = 1'b1;
      @(negedge clk_1khz); pill_pulse = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk_1khz); clr_n = 1'b0;
      @(negedge clk_1khz); clr_n = 1'b1;
   endtask

   task automatic wait_state(input string name, input logic [2:0] target, input int budget,
                             output int cycles);
      cycles = 0;
      while (state !== target && cycles < budget) begin
         @(negedge clk_1khz);
         cycles++;
      end
      chk(name, {29'd0, state}, {29'd0, target});
   endtask

   initial begin
      int cyc;
      int d0;
      bit saw_switch;
      tick(3);
      chk_en = 1'b1;
      clr_n = 1'b1;
      chk("rst_state", {29'd0, state}, 0);
      chk("rst_outs", {29'd0, hopper_en, conveyor_run, done}, 0);
      $display("txn reset state=%0d", state);

      // Normal run: 3 pills per bottle, 2 bottles.
      tgt_pills = 12'h003; tgt_bottles = 8'h02; conveyor_ok = 1'b1;
      d0 = done_cnt;
      saw_switch = 1'b0;
      pulse_start();
      chk("run_enter", {29'd0, state}, 1);
      for (int i = 0; i < 40 && state !== 3'd3; i++) begin
         tick(99);
         pulse_pill();
         if (state === 3'd2) saw_switch = 1'b1;
      end
      wait_state("run_done", 3'd3, 300, cyc);
      tick(2);
      chk("run_saw_switch", {31'd0, saw_switch}, 1);
      chk("run_bottles", {24'd0, now_bottles}, 32'h02);
      chk("run_done_once", done_cnt - d0, 1);
      pulse_start();
      chk("done_to_setting", {29'd0, state}, 0);
      chk("done_held_bottles", {24'd0, now_bottles}, 32'h02);
      $display("txn normal_run bottles=%0h", now_bottles);

      // Hopper timeout after two pills, then resume.
      tgt_pills = 12'h005;
      pulse_start();
      pulse_pill(); tick(10); pulse_pill();
      wait_state("hop_error", 3'd4, 3500, cyc);
      chk("hop_cycles", cyc, 3001);
      chk("hop_err", {30'd0, err_code}, 1);
      chk("hop_pills_kept", {20'd0, now_pills}, 32'h002);
      pulse_start();
      chk("hop_resume", {29'd0, state}, 1);
      chk("hop_resume_pills", {20'd0, now_pills}, 32'h002);
      $display("txn hopper_timeout cycles=%0d", cyc);

      // BCD carry across two digits.
      pulse_reset();
      tgt_pills = 12'h120; tgt_bottles = 8'h05;
      pulse_start();
      for (int i = 0; i < 109; i++) begin tick(3); pulse_pill(); end
      chk("bcd_109", {20'd0, now_pills}, 32'h109);
      pulse_pill();
      chk("bcd_110", {20'd0, now_pills}, 32'h110);
      $display("txn bcd_carry pills=%0h", now_pills);

      // Conveyor fault at the end of the switch dwell.
      for (int i = 0; i < 9; i++) begin tick(3); pulse_pill(); end
      conveyor_ok = 1'b0;
      tick(3); pulse_pill();
      wait_state("conv_error", 3'd4, 2500, cyc);
      chk("conv_cycles", cyc, 2002);
      chk("conv_err", {30'd0, err_code}, 2);
      conveyor_ok = 1'b1;
      pulse_start();
      chk("conv_resume_switch", {29'd0, state}, 2);
      wait_state("conv_resume_run", 3'd1, 2500, cyc);
      chk("conv_resume_cycles", cyc, 2001);
      $display("txn conveyor_fault cycles=%0d", cyc);

      // Emergency stop mid-switch; only reset leaves FATAL.
      for (int i = 0; i < 120; i++) begin tick(3); pulse_pill(); end
      tick(50);
      chk("estop_pre_switch", {29'd0, state}, 2);
      estop = 1'b1;
      tick(2);
      chk("estop_state", {29'd0, state}, 5);
      chk("estop_err", {30'd0, err_code}, 3);
      estop = 1'b0;
      pulse_start();
      tick(2);
      chk("fatal_ignores_start", {29'd0, state}, 5);
      pulse_reset();
      chk("fatal_clr_state", {29'd0, state}, 0);
      chk("fatal_clr_counts", {12'd0, now_pills, now_bottles}, 0);
      chk("fatal_clr_err", {30'd0, err_code}, 0);
      $display("txn estop_fatal state=%0d", state);

      // Completing pill lands on the timeout cycle.
      tgt_pills = 12'h001; tgt_bottles = 8'h02;
      pulse_start();
      tick(HOP_CYC - 1);
      pulse_pill();
      tick(1);
      chk("race_switch", {29'd0, state}, 2);
      chk("race_bottles", {24'd0, now_bottles}, 32'h01);
      $display("txn complete_vs_timeout state=%0d", state);

      // Zero bottle target must not start.
      pulse_reset();
      tgt_bottles = 8'h00;
      pulse_start();
      tick(2);
      chk("zero_tgt_stays", {29'd0, state}, 0);
      chk("zero_tgt_hopper", {31'd0, hopper_en}, 0);
      $display("txn zero_target state=%0d", state);

      tick(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fill_sequencer.md
FILL_SEQUENCER -- requirements
Module: fill_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 1000, meaning clk_1khz cycles per second.
REQ-002 SHALL have parameter SWITCH_S, default 2, meaning the bottle-switch dwell in seconds.
REQ-003 SHALL have parameter HOPPER_S, default 3, meaning the number of seconds without a pill before a hopper fault.
REQ-004 SHALL have one clock and a synchronous, active-low reset; clk_1khz is the single clock; clr_n is the reset.
REQ-005 SHALL have ports (name, direction, width, meaning):
- clk_1khz, in, 1, system clock.
- clr_n, in, 1, synchronous active-low reset.
- start, in, 1, single-cycle start/resume pulse.
- pill_pulse, in, 1, single-cycle pill-dropped pulse.
- conveyor_ok, in, 1, conveyor running.
- estop, in, 1, emergency stop, level.
- tgt_pills, in, 12, BCD target pills per bottle, 3 digits.
- tgt_bottles, in, 8, BCD target bottles, 2 digits.
- state, out, 3, current state.
- now_pills, out, 12, BCD pills in current bottle.
- now_bottles, out, 8, BCD completed bottles.
- hopper_en, out, 1, hopper feed enable.
- conveyor_run, out, 1, conveyor drive.
- err_code, out, 2, fault cause.
- done, out, 1, one-cycle pulse on entering DONE.

Function
REQ-006 SHALL use state encodings SETTING=0, RUNNING=1, SWITCHING=2, DONE=3, ERROR=4, FATAL=5; states 6-7 SHALL go to SETTING on the next edge.
REQ-007 SHALL generate a 1 s tick from a prescaler counting 0..CLK_HZ-1; the tick is asserted when the count is CLK_HZ-1; the prescaler SHALL restart at 0 whenever either timer is loaded.
REQ-008 In SETTING, start with nonzero tgt_pills and nonzero tgt_bottles SHALL clear now_pills and now_bottles, load hopper_timer=HOPPER_S, and enter RUNNING on the next edge; start with either target zero SHALL be ignored.
REQ-009 In RUNNING, pill_pulse SHALL BCD-increment now_pills and reload hopper_timer=HOPPER_S.
- Each digit wraps 9->0 with a carry to the next digit; 999 wraps to 000.
REQ-010 In RUNNING, when the registered now_pills equals tgt_pills, the sequencer SHALL, on that edge:
- clear now_pills and BCD-increment now_bottles;
- enter DONE if the incremented now_bottles equals tgt_bottles;
- otherwise load switch_timer=SWITCH_S and enter SWITCHING.
This is one cycle of latency after the completing pill. A pill_pulse arriving in that same cycle SHALL be discarded.
REQ-011 In RUNNING, the tick SHALL decrement hopper_timer; hopper_timer==0 SHALL enter ERROR with err_code=1. Bottle completion SHALL take priority over timeout in the same cycle.
REQ-012 In SWITCHING, the tick SHALL decrement switch_timer; at switch_timer==0:
- conveyor_ok=1 SHALL reload hopper_timer and enter RUNNING;
- conveyor_ok=0 SHALL enter ERROR with err_code=2.
REQ-013 pill_pulse SHALL be ignored in every state except RUNNING.
REQ-014 In ERROR, start SHALL clear err_code and resume without altering the counts:
- err_code 1 resumes to RUNNING with hopper_timer reloaded;
- err_code 2 resumes to SWITCHING with switch_timer reloaded.
REQ-015 In DONE, start SHALL enter SETTING; the counts SHALL be held.
REQ-016 estop=1 in any state other than SETTING SHALL enter FATAL with err_code=3 on the next edge, overriding all other transitions. FATAL SHALL be left only by clr_n.
REQ-017 Outputs SHALL be registered Moore outputs:
- hopper_en=1 only in RUNNING;
- conveyor_run=1 only in SWITCHING;
- done SHALL be high for exactly the first cycle in DONE.

Reset
REQ-018 clr_n=0 at a clock edge SHALL force all registers to their reset values, including mid-RUNNING and FATAL:
- state=SETTING;
- now_pills=0, now_bottles=0;
- timers=0, prescaler=0;
- err_code=0;
- hopper_en=0, conveyor_run=0, done=0.

Structure
REQ-019 A shared package fill_pkg SHALL hold the state encodings, err_code values (0 none, 1 hopper, 2 conveyor, 3 estop) and the default timing constants.
REQ-020 A sub-module bcd_counter SHALL be used for now_pills and now_bottles. It SHALL be parameterised by digit count, with synchronous clr and inc inputs and per-digit wrap and carry.

Verification
REQ-021 Normal run: tgt_pills=003, tgt_bottles=02, start, then pills every 100 cycles.
- State goes 1 -> 2 -> (after 2000 cycles, conveyor_ok=1) 1 -> 3.
- now_bottles ends at 02; done pulses once.
REQ-022 Hopper timeout: in RUNNING with no pill_pulse for 3000 cycles, the state SHALL be 4 with err_code=1.
- start then resumes to 1 with now_pills unchanged.
REQ-023 Conveyor fault: conveyor_ok=0 throughout SWITCHING leads to state=4, err_code=2 at 2000 cycles after entry.
- start with conveyor_ok=1 returns to 2, then after 2000 cycles to 1.
REQ-024 BCD carry: with tgt_pills=120, 109 pills SHALL show now_pills=0x109; one more pill SHALL show 0x110.
REQ-025 estop asserted mid-SWITCHING SHALL give state=5, err_code=3.
- start SHALL be ignored in FATAL.
- clr_n low for one edge SHALL give state=0 with all counts 0.
REQ-026 The completing pill and a timeout in the same cycle SHALL resolve to SWITCHING, not ERROR.
- start with tgt_bottles=00 SHALL stay in SETTING.
